ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_3000, first fetch address.
REQ-002 The block SHALL have parameter IM_LIMIT, default 32'h0000_6FFF, highest legal byte address of instruction memory.
REQ-003 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port npc_sel  input  3  next-PC select: 0 PC4, 1 BRANCH, 2 JUMP, 3 JR, 4-7 treated as PC4.
REQ-006 The block SHALL have port zero  input  1  branch condition, taken when high.
REQ-007 The block SHALL have port imm16  input  16  branch offset in words.
REQ-008 The block SHALL have port instr_index  input  26  jump target field.
REQ-009 The block SHALL have port rs_data  input  32  jump-register target.
REQ-010 The block SHALL have port upd  input  1  datapath commit strobe for the current instruction.
REQ-011 The block SHALL have port imem_req  output  1  fetch request.
REQ-012 The block SHALL have port imem_addr  output  32  fetch byte address, equal to pc.
REQ-013 The block SHALL have port imem_ack  input  1  fetch data valid.
REQ-014 The block SHALL have port imem_rdata  input  32  fetched word.
REQ-015 The block SHALL have port instr  output  32  latched instruction, which supplies opcode [31:26] and funct [5:0] to the decoder.
REQ-016 The block SHALL have port instr_valid  output  1  instr holds the word at pc.
REQ-017 The block SHALL have ports pc and pc4  output  32 each  current PC and PC+4.
REQ-018 The block SHALL have port retired  output  32  committed-instruction count.
REQ-019 The block SHALL have port addr_exc  output  1  sticky illegal next-PC flag.

Function
REQ-020 The FSM SHALL have states START, FETCH, HOLD and ERROR, with state encoding free.
REQ-021 From START, the next edge SHALL enter FETCH, and imem_req SHALL be high in FETCH only.
REQ-022 In FETCH, imem_addr SHALL stay stable, and on an edge with imem_ack=1 the block SHALL latch instr<=imem_rdata, set instr_valid=1 and enter HOLD, so instr_valid is high one cycle after ack.
REQ-023 imem_ack SHALL be ignored outside FETCH, and upd SHALL be ignored outside HOLD.
REQ-024 In HOLD with upd=1, on the edge the block SHALL compute npc, clear instr_valid, increment retired (32-bit wrap from FFFF_FFFF to 0), load pc<=npc and enter FETCH.
REQ-025 npc for PC4 SHALL be pc+4.
REQ-026 npc for BRANCH SHALL be pc+4+(sign-extended imm16<<2) when zero=1, and pc+4 otherwise.
REQ-027 npc for JUMP SHALL be {pc4[31:28], instr_index, 2'b00}.
REQ-028 npc for JR SHALL be rs_data.
REQ-029 All npc arithmetic SHALL be modulo 2^32.
REQ-030 If npc[1:0]!=0, npc<PC_RESET or npc>IM_LIMIT, the block SHALL leave pc unchanged, set addr_exc=1, keep instr_valid=0, still increment retired, and enter ERROR.
REQ-031 ERROR SHALL be absorbing until reset, with imem_req=0 and upd ignored.
REQ-032 In HOLD with upd=0, all outputs SHALL hold indefinitely.
REQ-033 pc4 SHALL always equal pc+4 combinationally, and imem_addr SHALL always equal pc.

Reset
REQ-034 Asserting reset SHALL immediately force state=START, pc=PC_RESET, instr=0, instr_valid=0, imem_req=0, retired=0 and addr_exc=0, including mid-FETCH or in ERROR.
REQ-035 An imem_ack coincident with, or pending across, reset SHALL be discarded.
REQ-036 After reset deasserts, imem_req SHALL rise on the first edge and imem_addr SHALL be 0x3000.

Verification
REQ-037 The bench SHALL check: reset, then ack on the 3rd FETCH cycle with rdata=0x3C01_1234 -> instr=0x3C01_1234 and instr_valid=1 one cycle later, and pc=0x3000.
REQ-038 The bench SHALL check: pc=0x3000, npc_sel=1, zero=1, imm16=0xFFFF, upd -> pc=0x3000; with zero=0 -> pc=0x3004; with imm16=0x0003 and zero=1 -> pc=0x3010.
REQ-039 The bench SHALL check: pc=0x3008, npc_sel=2, instr_index=0x0000C10 -> pc=0x3040, retired incremented by 1.
REQ-040 The bench SHALL check: npc_sel=3, rs_data=0x3002 -> addr_exc=1, pc unchanged, imem_req stays 0; rs_data=0x7000 -> same.
REQ-041 The bench SHALL check: upd pulsed during FETCH and ack pulsed during HOLD -> no state, pc or retired change.
REQ-042 The bench SHALL check: reset asserted mid-FETCH with ack high -> instr=0, instr_valid=0, pc=0x3000 without waiting for a clock edge.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch channel between the fetch unit (master) and the memory (slave).
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: requests the word at pc, holds it until the datapath commits,
// then advances pc by PC4/BRANCH/JUMP/JR and traps on illegal next-PC values.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         npc_sel,
  input  logic               zero,
  input  logic [15:0]        imm16,
  input  logic [25:0]        instr_index,
  input  logic [31:0]        rs_data,
  input  logic               upd,
  ifu_fetch_if.master        imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc4,
  output logic [31:0]        retired,
  output logic               addr_exc
);

  typedef enum logic [1:0] {START, FETCH, HOLD, ERROR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        vld_q, vld_d;
  logic [31:0] ret_q, ret_d;
  logic        exc_q, exc_d;
  logic [31:0] npc;
  logic        npc_ok;

  function automatic logic [31:0] calc_npc(
    input logic [31:0] cur_pc,
    input logic [2:0]  sel,
    input logic        z,
    input logic [15:0] imm,
    input logic [25:0] idx,
    input logic [31:0] rs
  );
    logic [31:0]        p4;
    logic signed [31:0] boff;
    p4   = cur_pc + 32'd4;
    boff = {{14{imm[15]}}, imm, 2'b00};
    case (sel)
      3'd1:    calc_npc = z ? (p4 + unsigned'(boff)) : p4;
      3'd2:    calc_npc = {p4[31:28], idx, 2'b00};
      3'd3:    calc_npc = rs;
      default: calc_npc = p4;
    endcase
  endfunction

  function automatic logic npc_legal(input logic [31:0] a);
    npc_legal = (a[1:0] == 2'b00) && (a >= PC_RESET) && (a <= IM_LIMIT);
  endfunction

  assign npc    = calc_npc(pc_q, npc_sel, zero, imm16, instr_index, rs_data);
  assign npc_ok = npc_legal(npc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= START;
      pc_q    <= PC_RESET;
      instr_q <= 32'd0;
      vld_q   <= 1'b0;
      ret_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      ret_q   <= ret_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    ret_d   = ret_q;
    exc_d   = exc_q;
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (upd) begin
          vld_d = 1'b0;
          ret_d = ret_q + 32'd1;
          // An illegal target still retires the instruction but leaves pc pointing at it.
          if (npc_ok) begin
            pc_d    = npc;
            state_d = FETCH;
          end else begin
            exc_d   = 1'b1;
            state_d = ERROR;
          end
        end
      end
      default: state_d = ERROR;
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = vld_q;
  assign pc             = pc_q;
  assign pc4            = pc_q + 32'd4;
  assign retired        = ret_q;
  assign addr_exc       = exc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed literal scenarios followed by randomized traffic,
// with every cycle compared against a behavioural fetch/commit model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  npc_sel = 3'd0;
  logic        zero = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] rs_data = 32'd0;
  logic        upd = 1'b0;
  logic [31:0] instr, pc, pc4, retired;
  logic        instr_valid, addr_exc;

  ifu_fetch_if imem_if();

  ifu_fetch dut (
    .clk(clk), .reset(reset), .npc_sel(npc_sel), .zero(zero), .imm16(imm16),
    .instr_index(instr_index), .rs_data(rs_data), .upd(upd), .imem(imem_if),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc4(pc4),
    .retired(retired), .addr_exc(addr_exc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Phase: 0 just out of reset, 1 waiting for memory,
  // 2 holding a word for the datapath, 3 trapped.
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h3000;
  logic [31:0] m_instr = 32'd0;
  logic        m_vld = 1'b0;
  logic [31:0] m_ret = 32'd0;
  logic        m_exc = 1'b0;

  function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [2:0] sel,
                                          input logic z, input logic [15:0] imm,
                                          input logic [25:0] idx, input logic [31:0] rs);
    int off;
    off = $signed(imm);
    if (sel == 3'd1 && z)  return p + 32'd4 + 32'(off * 4);
    if (sel == 3'd2)       return ((p + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    if (sel == 3'd3)       return rs;
    return p + 32'd4;
  endfunction

  function automatic bit ref_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFF);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_pc <= 32'h3000; m_instr <= 32'd0;
      m_vld <= 1'b0; m_ret <= 32'd0; m_exc <= 1'b0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      if (imem_if.imem_ack) begin
        m_instr <= imem_if.imem_rdata; m_vld <= 1'b1; m_phase <= 2;
      end
    end else if (m_phase == 2 && upd) begin
      m_vld <= 1'b0;
      m_ret <= m_ret + 32'd1;
      if (ref_legal(ref_npc(m_pc, npc_sel, zero, imm16, instr_index, rs_data))) begin
        m_pc <= ref_npc(m_pc, npc_sel, zero, imm16, instr_index, rs_data);
        m_phase <= 1;
      end else begin
        m_exc <= 1'b1; m_phase <= 3;
      end
    end
  end

  always @(negedge clk) begin
    check("m_req",   {31'd0, imem_if.imem_req}, {31'd0, m_phase == 1});
    check("m_addr",  imem_if.imem_addr, m_pc);
    check("m_pc",    pc, m_pc);
    check("m_pc4",   pc4, m_pc + 32'd4);
    check("m_instr", instr, m_instr);
    check("m_vld",   {31'd0, instr_valid}, {31'd0, m_vld});
    check("m_ret",   retired, m_ret);
    check("m_exc",   {31'd0, addr_exc}, {31'd0, m_exc});
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic fetch_word(input logic [31:0] w);
    int n = 0;
    while (!imem_if.imem_req && n < 20) begin @(negedge clk); n++; end
    if (!imem_if.imem_req) check("fetch_req_timeout", {31'd0, imem_if.imem_req}, 32'd1);
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = w;
    @(negedge clk);
    imem_if.imem_ack = 1'b0;
  endtask

  task automatic commit(input logic [2:0] sel, input logic z, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] rs);
    npc_sel = sel; zero = z; imm16 = imm; instr_index = idx; rs_data = rs; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic trap_case(input logic [31:0] target, input string tag);
    do_reset();
    fetch_word(32'h0000_0008);
    commit(3'd3, 1'b0, 16'd0, 26'd0, target);
    check({tag, "_exc"}, {31'd0, addr_exc}, 32'd1);
    check({tag, "_pc"}, pc, 32'h3000);
    check({tag, "_ret"}, retired, 32'd1);
    check({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
    imem_if.imem_ack = 1'b1; upd = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check({tag, "_req"}, {31'd0, imem_if.imem_req}, 32'd0);
    end
    imem_if.imem_ack = 1'b0; upd = 1'b0;
    check({tag, "_pc_held"}, pc, 32'h3000);
    check({tag, "_ret_held"}, retired, 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imem_if.imem_ack = 1'b0;
    imem_if.imem_rdata = 32'd0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_instr", instr, 32'd0);
    check("rst_vld", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
    check("rst_pc", pc, 32'h3000);
    check("rst_ret", retired, 32'd0);
    check("rst_exc", {31'd0, addr_exc}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("first_req", {31'd0, imem_if.imem_req}, 32'd1);
    check("first_addr", imem_if.imem_addr, 32'h3000);
    @(negedge clk);
    @(negedge clk);
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h3C01_1234;
    check("pre_ack_vld", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    imem_if.imem_ack = 1'b0;
    check("ack_instr", instr, 32'h3C01_1234);
    check("ack_vld", {31'd0, instr_valid}, 32'd1);
    check("ack_pc", pc, 32'h3000);

    // Branch cases, each starting from pc=0x3000.
    commit(3'd1, 1'b1, 16'hFFFF, 26'd0, 32'd0);
    check("br_back_pc", pc, 32'h3000);
    check("br_back_ret", retired, 32'd1);
    do_reset(); fetch_word(32'h1000_0001);
    commit(3'd1, 1'b0, 16'hFFFF, 26'd0, 32'd0);
    check("br_nt_pc", pc, 32'h3004);
    do_reset(); fetch_word(32'h1000_0003);
    commit(3'd1, 1'b1, 16'h0003, 26'd0, 32'd0);
    check("br_fwd_pc", pc, 32'h3010);
    check("br_fwd_req", {31'd0, imem_if.imem_req}, 32'd1);

    // Jump from 0x3008.
    do_reset();
    fetch_word(32'd0); commit(3'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    fetch_word(32'd0); commit(3'd5, 1'b1, 16'h0040, 26'd0, 32'd0);
    check("j_pre_pc", pc, 32'h3008);
    check("j_pre_ret", retired, 32'd2);
    fetch_word(32'h0800_0C10);
    commit(3'd2, 1'b0, 16'd0, 26'h0000C10, 32'd0);
    check("j_pc", pc, 32'h3040);
    check("j_pc4", pc4, 32'h3044);
    check("j_ret", retired, 32'd3);

    trap_case(32'h0000_3002, "jr_misalign");
    trap_case(32'h0000_7000, "jr_above");
    trap_case(32'h0000_2FFC, "jr_below");
    do_reset(); fetch_word(32'd0);
    commit(3'd3, 1'b0, 16'd0, 26'd0, 32'h6FFC);
    check("jr_top_pc", pc, 32'h6FFC);
    check("jr_top_exc", {31'd0, addr_exc}, 32'd0);

    // Stray strobes outside their phase.
    do_reset();
    @(negedge clk);
    npc_sel = 3'd3; rs_data = 32'h4000; upd = 1'b1;
    @(negedge clk); upd = 1'b0;
    check("upd_fetch_pc", pc, 32'h3000);
    check("upd_fetch_ret", retired, 32'd0);
    check("upd_fetch_req", {31'd0, imem_if.imem_req}, 32'd1);
    fetch_word(32'h1111_1111);
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h2222_2222;
    repeat (2) @(negedge clk);
    imem_if.imem_ack = 1'b0;
    check("ack_hold_instr", instr, 32'h1111_1111);
    check("ack_hold_vld", {31'd0, instr_valid}, 32'd1);
    check("ack_hold_req", {31'd0, imem_if.imem_req}, 32'd0);

    // Asynchronous reset mid-fetch with an acknowledge in flight.
    commit(3'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    check("pre_rst_instr", instr, 32'h1111_1111);
    imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h3333_3333;
    #2 reset = 1'b1;
    #1;
    check("arst_instr", instr, 32'd0);
    check("arst_vld", {31'd0, instr_valid}, 32'd0);
    check("arst_pc", pc, 32'h3000);
    check("arst_ret", retired, 32'd0);
    check("arst_req", {31'd0, imem_if.imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_vld", {31'd0, instr_valid}, 32'd0);
    check("post_rst_instr", instr, 32'd0);
    check("post_rst_req", {31'd0, imem_if.imem_req}, 32'd1);
    imem_if.imem_ack = 1'b0;

    // Randomized traffic, checked every cycle by the model comparator.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      imem_if.imem_ack   = ($urandom_range(0, 2) == 0);
      imem_if.imem_rdata = $urandom;
      upd     = ($urandom_range(0, 2) == 0);
      npc_sel = 3'($urandom_range(0, 7));
      zero    = 1'($urandom_range(0, 1));
      imm16   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
      instr_index = ($urandom_range(0, 4) == 0) ? 26'($urandom)
                                                : 26'($urandom_range(32'hC00, 32'h1BFF));
      case ($urandom_range(0, 5))
        0:       rs_data = $urandom;
        1:       rs_data = 32'h7000;
        2:       rs_data = 32'h2FFC;
        3:       rs_data = 32'($urandom_range(32'h3000, 32'h6FFF));
        default: rs_data = 32'($urandom_range(32'hC00, 32'h1BFF)) << 2;
      endcase
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
